rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, legal range 1..15: the maximum number of consecutive cycles a pending LU request may be refused.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- wb_valid  in  1  pipeline write-back request
- wb_dest  in  5  WB destination register
- wb_data  in  32  WB write data
- wb_ready  out  1  WB request accepted this cycle when high with wb_valid
- lu_valid  in  1  long-latency unit (mul/div/load return) write request
- lu_dest  in  5  LU destination register
- lu_data  in  32  LU write data
- lu_ready  out  1  LU request accepted this cycle when high with lu_valid
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- rf_src  out  1  source of the current write: 0=WB, 1=LU
- lu_starved  out  1  high while starve_cnt equals STARVE_LIMIT

Function
REQ-003 The block SHALL accept a requester's write only in a cycle where its valid and ready are both high, and SHALL accept at most one write per cycle.
REQ-004 The block SHALL hold a 4-bit starve_cnt register, with force = lu_valid && (starve_cnt == STARVE_LIMIT).
REQ-005 The block SHALL drive wb_ready = !force and lu_ready = force || !wb_valid, both combinationally, with no dependence on the outputs of the write register.
REQ-006 When both valid and force is low, the block SHALL grant WB; when force is high, it SHALL grant LU and refuse WB for that cycle.
REQ-007 starve_cnt SHALL increment by 1 in a cycle with lu_valid && !lu_ready, saturating at STARVE_LIMIT.
REQ-008 starve_cnt SHALL clear to 0 in a cycle where LU is accepted or lu_valid is low.
REQ-009 The block SHALL register the accepted write: one cycle after acceptance, it SHALL drive rf_waddr=dest, rf_wdata=data and rf_src=granted source (latency exactly 1 cycle).
REQ-010 In that cycle rf_we SHALL be 1 if dest != 0 and 0 if dest == 0 (writes to $0 are consumed but suppressed).
REQ-011 In a cycle following no acceptance, the block SHALL drive rf_we=0, rf_waddr=0, rf_wdata=0 and rf_src=0.
REQ-012 Back-to-back acceptances SHALL produce writes on consecutive cycles with no bubble; sustained throughput SHALL be one write per cycle.
REQ-013 When WB and LU target the same dest in the same cycle, the granted write SHALL appear first and the refused one in a later cycle, so the refused value is final.
REQ-014 Requesters SHALL hold valid, dest and data stable until accepted; the block SHALL sample only at acceptance.
REQ-015 With STARVE_LIMIT=N and WB valid every cycle, a continuously pending LU request SHALL be accepted in its (N+1)th cycle of pendency, and never later.
REQ-016 lu_starved SHALL equal (starve_cnt == STARVE_LIMIT), a registered-state-derived signal.

Reset
REQ-017 On reset assertion, the block SHALL clear starve_cnt and the write register immediately, regardless of clk.
REQ-018 While reset is high, the block SHALL drive rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0 and lu_starved=0.
REQ-019 While reset is high, the block SHALL drive wb_ready=1 and lu_ready=!wb_valid.
REQ-020 A write accepted in the cycle reset asserts SHALL be discarded and never appear on rf_we.
REQ-021 After reset deassertion, the first clk edge SHALL operate normally with starve_cnt=0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- WB only: wb_valid=1, dest=5, data=0x12345678 -> wb_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, rf_src=0.
- $0 write: LU only, dest=0, data=0xFFFFFFFF -> lu_ready=1; next cycle rf_we=0, rf_src=1.
- Starvation, STARVE_LIMIT=4: WB valid every cycle, LU held at dest=9 from cycle 0 -> lu_ready=0 in cycles 0-3, lu_starved=1 and lu_ready=1, wb_ready=0 in cycle 4; rf_waddr=9, rf_src=1 in cycle 5; starve_cnt=0 in cycle 5.
- Same dest: both valid, dest=7, WB=0xA, LU=0xB -> rf_wdata=0xA at T+1; rf_wdata=0xB later; last write to r7 = 0xB.
- Async reset mid-stream: reset pulsed between clk edges, starve_cnt=3 -> outputs 0 at once; lu_starved=0; no pending write emitted after release.
- Back-to-back: WB valid 8 cycles, dests 1..8, LU idle -> rf_we=1 for 8 consecutive cycles, addresses 1..8 in order.

Source files
------------

// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if: write-back / long-latency-unit request bus and register-file write port
//   wb_valid/wb_dest/wb_data/wb_ready : pipeline write-back request and its acceptance
//   lu_valid/lu_dest/lu_data/lu_ready : long-latency unit write request and its acceptance
//   rf_we/rf_waddr/rf_wdata/rf_src    : registered register-file write (src 0=WB, 1=LU)
//   lu_starved                        : LU has been refused the maximum number of cycles
interface rf_wr_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_src;
    logic        lu_starved;

    modport master (
        output wb_valid, wb_dest, wb_data, lu_valid, lu_dest, lu_data,
        input  wb_ready, lu_ready, rf_we, rf_waddr, rf_wdata, rf_src, lu_starved
    );

    modport slave (
        input  wb_valid, wb_dest, wb_data, lu_valid, lu_dest, lu_data,
        output wb_ready, lu_ready, rf_we, rf_waddr, rf_wdata, rf_src, lu_starved
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: single-port register-file write arbiter, WB priority with bounded LU starvation
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset
//   bus   : rf_wr_arbiter_if slave (requests in, readies and registered write out)
module rf_wr_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           reset,
    rf_wr_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt, starve_cnt_next;
    logic        force_lu, wb_acc, lu_acc;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        we_q, src_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;

    // Once LU has waited STARVE_LIMIT cycles it wins outright and WB is held off.
    assign force_lu     = bus.lu_valid && (starve_cnt == LIMIT);
    assign bus.wb_ready = !force_lu;
    assign bus.lu_ready = force_lu || !bus.wb_valid;
    // The ready equations make these two mutually exclusive.
    assign wb_acc       = bus.wb_valid && bus.wb_ready;
    assign lu_acc       = bus.lu_valid && bus.lu_ready;

    always_comb begin
        dest = wb_acc ? bus.wb_dest : lu_acc ? bus.lu_dest : 5'd0;
        data = wb_acc ? bus.wb_data : lu_acc ? bus.lu_data : 32'd0;
        starve_cnt_next = (bus.lu_valid && !bus.lu_ready)
                        ? ((starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1)
                        : 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
            we_q       <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            src_q      <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next;
            // Writes to $0 are consumed but never enable the register file.
            we_q       <= (wb_acc || lu_acc) && (dest != 5'd0);
            waddr_q    <= dest;
            wdata_q    <= data;
            src_q      <= lu_acc;
        end
    end

    assign bus.rf_we      = we_q;
    assign bus.rf_waddr   = waddr_q;
    assign bus.rf_wdata   = wdata_q;
    assign bus.rf_src     = src_q;
    assign bus.lu_starved = (starve_cnt == LIMIT);
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed and randomized checks of rf_wr_arbiter against a behavioural model
module tb_rf_wr_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int refusals = 0;
    logic last_wb_acc = 1'b0;
    logic last_lu_acc = 1'b0;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf [32];

    rf_wr_arbiter_if bus ();

    rf_wr_arbiter #(.STARVE_LIMIT(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the currently driven requests; starts and ends just after a posedge.
    task automatic step();
        logic forced, g_wb, g_lu, lv, wv;
        logic [4:0] d;
        logic [31:0] x;
        #1;
        lv = bus.lu_valid;
        wv = bus.wb_valid;
        forced = lv && (refusals == N);
        g_lu = forced || (lv && !wv);
        g_wb = wv && !g_lu;
        d = g_wb ? bus.wb_dest : g_lu ? bus.lu_dest : 5'd0;
        x = g_wb ? bus.wb_data : g_lu ? bus.lu_data : 32'd0;
        chk("wb_ready", bus.wb_ready, !forced);
        chk("lu_ready", bus.lu_ready, lv ? g_lu : !wv);
        chk("lu_starved", bus.lu_starved, refusals == N);
        @(posedge clk);
        #1;
        chk("rf_we", bus.rf_we, (g_wb || g_lu) && d != 5'd0);
        chk("rf_waddr", bus.rf_waddr, d);
        chk("rf_wdata", bus.rf_wdata, x);
        chk("rf_src", bus.rf_src, g_lu);
        if ((g_wb || g_lu) && d != 5'd0) model_rf[d] = x;
        if (bus.rf_we === 1'b1) dut_rf[bus.rf_waddr] = bus.rf_wdata;
        refusals = (lv && !g_lu) ? ((refusals + 1 > N) ? N : refusals + 1) : 0;
        last_wb_acc = g_wb;
        last_lu_acc = g_lu;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = 32'd0;
            dut_rf[i] = 32'd0;
        end
        bus.wb_valid = 1'b0; bus.wb_dest = 5'd0; bus.wb_data = 32'd0;
        bus.lu_valid = 1'b0; bus.lu_dest = 5'd0; bus.lu_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        chk("rst_lu_starved", bus.lu_starved, 0);
        chk("rst_wb_ready", bus.wb_ready, 1);
        chk("rst_lu_ready", bus.lu_ready, 1);
        reset = 1'b0;

        // WB only
        bus.wb_valid = 1'b1; bus.wb_dest = 5'd5; bus.wb_data = 32'h12345678;
        #1 chk("wbonly_ready", bus.wb_ready, 1);
        step();
        chk("wbonly_we", bus.rf_we, 1);
        chk("wbonly_addr", bus.rf_waddr, 5);
        chk("wbonly_data", bus.rf_wdata, 32'h12345678);
        chk("wbonly_src", bus.rf_src, 0);

        // LU write to $0 is consumed without enabling the register file
        bus.wb_valid = 1'b0;
        bus.lu_valid = 1'b1; bus.lu_dest = 5'd0; bus.lu_data = 32'hFFFFFFFF;
        #1 chk("zero_lu_ready", bus.lu_ready, 1);
        step();
        chk("zero_we", bus.rf_we, 0);
        chk("zero_src", bus.rf_src, 1);
        bus.lu_valid = 1'b0;
        step();

        // Starvation: WB valid every cycle, LU pending from cycle 0
        bus.lu_valid = 1'b1; bus.lu_dest = 5'd9; bus.lu_data = 32'h99990009;
        for (int c = 0; c <= N; c++) begin
            bus.wb_valid = 1'b1; bus.wb_dest = 5'(10 + c); bus.wb_data = 32'(c);
            #1;
            chk("starve_lu_ready", bus.lu_ready, c == N);
            chk("starve_flag", bus.lu_starved, c == N);
            if (c == N) chk("starve_wb_ready", bus.wb_ready, 0);
            step();
        end
        chk("starve_addr", bus.rf_waddr, 9);
        chk("starve_src", bus.rf_src, 1);
        chk("starve_cleared", bus.lu_starved, 0);
        bus.wb_valid = 1'b0; bus.lu_valid = 1'b0;
        step();

        // Same destination from both sides: WB lands first, LU value is final
        bus.wb_valid = 1'b1; bus.wb_dest = 5'd7; bus.wb_data = 32'hA;
        bus.lu_valid = 1'b1; bus.lu_dest = 5'd7; bus.lu_data = 32'hB;
        step();
        chk("same_first", bus.rf_wdata, 32'hA);
        bus.wb_valid = 1'b0;
        step();
        chk("same_second", bus.rf_wdata, 32'hB);
        bus.lu_valid = 1'b0;
        step();
        chk("same_final_r7", dut_rf[7], 32'hB);

        // Back-to-back WB writes
        for (int i = 1; i <= 8; i++) begin
            bus.wb_valid = 1'b1; bus.wb_dest = 5'(i); bus.wb_data = 32'h100 + 32'(i);
            step();
            chk("b2b_we", bus.rf_we, 1);
            chk("b2b_addr", bus.rf_waddr, i);
        end
        bus.wb_valid = 1'b0;
        step();

        // Randomized traffic honouring hold-until-accepted
        for (int i = 0; i < 400; i++) begin
            if (!bus.wb_valid || last_wb_acc) begin
                bus.wb_valid = ($urandom_range(0, 3) != 0);
                bus.wb_dest = 5'($urandom_range(0, 7));
                bus.wb_data = $urandom;
            end
            if (!bus.lu_valid || last_lu_acc) begin
                bus.lu_valid = ($urandom_range(0, 1) != 0);
                bus.lu_dest = 5'($urandom_range(0, 7));
                bus.lu_data = $urandom;
            end
            step();
        end
        bus.wb_valid = 1'b0; bus.lu_valid = 1'b0;
        step();
        for (int r = 0; r < 32; r++) chk($sformatf("rf_r%0d", r), dut_rf[r], model_rf[r]);

        // Async reset mid-stream with three refusals accumulated
        bus.lu_valid = 1'b1; bus.lu_dest = 5'd4; bus.lu_data = 32'h44;
        for (int c = 0; c < 3; c++) begin
            bus.wb_valid = 1'b1; bus.wb_dest = 5'd3; bus.wb_data = 32'h300 + 32'(c);
            step();
        end
        chk("pre_reset_we", bus.rf_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_we", bus.rf_we, 0);
        chk("arst_addr", bus.rf_waddr, 0);
        chk("arst_data", bus.rf_wdata, 0);
        chk("arst_src", bus.rf_src, 0);
        chk("arst_starved", bus.lu_starved, 0);
        chk("arst_wb_ready", bus.wb_ready, 1);
        chk("arst_lu_ready", bus.lu_ready, 0);
        @(posedge clk);
        #1;
        chk("arst_hold_we", bus.rf_we, 0);
        bus.wb_valid = 1'b0; bus.lu_valid = 1'b0;
        #1 chk("arst_lu_ready_idle", bus.lu_ready, 1);
        #1 reset = 1'b0;
        refusals = 0;
        step();
        chk("post_reset_we", bus.rf_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
